// File: rtl/win_banner_ctrl_pkg.sv
// Shared types and constants for the win banner controller.
//   banner_state_e : FSM state encoding (idle, reveal, blink, hold)
//   NUM_CHARS      : number of glyph slots in the banner
//   CHAR_PITCH     : horizontal distance in pixels between glyph slots
//   Slot*          : slot indices for "P", "1|2", " ", "W", "I", "N"
package win_banner_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReveal = 2'd1,
    StBlink  = 2'd2,
    StHold   = 2'd3
  } banner_state_e;

  localparam int unsigned NUM_CHARS  = 6;
  localparam int unsigned CHAR_PITCH = 32;

  localparam int unsigned SlotP     = 0;
  localparam int unsigned SlotNum   = 1;
  localparam int unsigned SlotSpace = 2;
  localparam int unsigned SlotW     = 3;
  localparam int unsigned SlotI     = 4;
  localparam int unsigned SlotN     = 5;

endpackage

// File: rtl/win_banner_ctrl_frame_counter.sv
// Frame counter: counts frame_tick pulses from 0 up to a terminal value, then wraps to 0.
//   clk, reset : clock and synchronous active-high reset
//   clear      : force the count to 0 (wins over tick)
//   tick       : advance request, one per video frame
//   term       : terminal count value
//   tc         : high while the count equals term
module win_banner_ctrl_frame_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic [Width-1:0] term,
  output logic             tc
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = (count_q == term) ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == term);

endmodule

// File: rtl/win_banner_ctrl.sv
// Win banner controller: after game_over, reveals "P1 WIN"/"P2 WIN" one glyph at a time, blinks
// the full banner BLINK_COUNT times, then holds it until restart.
//   clk, reset          : clock and synchronous active-high reset
//   frame_tick          : one pulse per video frame
//   game_over, winner   : start pulse and the winning player (0 = P1, 1 = P2)
//   restart             : return to idle
//   char_en             : per-slot glyph enables
//   base_x, base_y      : banner origin in pixels
//   winner_q            : latched winner, selects the glyph in slot 1
//   active              : high whenever the banner sequence is not idle
module win_banner_ctrl
  import win_banner_ctrl_pkg::*;
#(
  parameter int unsigned REVEAL_FRAMES = 8,
  parameter int unsigned BLINK_FRAMES  = 15,
  parameter int unsigned BLINK_COUNT   = 3,
  parameter int unsigned BASE_X        = 224,
  parameter int unsigned BASE_Y        = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 game_over,
  input  logic                 winner,
  input  logic                 restart,
  output logic [NUM_CHARS-1:0] char_en,
  output logic [9:0]           base_x,
  output logic [9:0]           base_y,
  output logic                 winner_q,
  output logic                 active
);

  localparam int unsigned MaxFrames = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES
                                                                      : BLINK_FRAMES;
  localparam int unsigned FcntW     = (MaxFrames > 1) ? $clog2(MaxFrames) : 1;
  localparam int unsigned BcntW     = $clog2(BLINK_COUNT) + 1;

  localparam logic [FcntW-1:0] RevealTerm = FcntW'(REVEAL_FRAMES - 1);
  localparam logic [FcntW-1:0] BlinkTerm  = FcntW'(BLINK_FRAMES - 1);

  banner_state_e        state_d, state_q;
  logic [NUM_CHARS-1:0] char_en_d, char_en_q;
  logic [BcntW-1:0]     bcnt_d, bcnt_q;
  logic                 winner_d, winner_qq;
  logic                 active_d, active_q;
  logic [9:0]           base_x_q, base_y_q;

  logic             fcnt_clear;
  logic             fcnt_tc;
  logic             phase_done;
  logic [FcntW-1:0] fcnt_term;

  assign fcnt_term  = (state_q == StBlink) ? BlinkTerm : RevealTerm;
  assign phase_done = frame_tick & fcnt_tc;

  win_banner_ctrl_frame_counter #(
    .Width (FcntW)
  ) u_frame_counter (
    .clk   (clk),
    .reset (reset),
    .clear (fcnt_clear),
    .tick  (frame_tick),
    .term  (fcnt_term),
    .tc    (fcnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    char_en_d  = char_en_q;
    bcnt_d     = bcnt_q;
    winner_d   = winner_qq;
    fcnt_clear = 1'b0;
    if (restart) begin
      state_d    = StIdle;
      char_en_d  = '0;
      bcnt_d     = '0;
      fcnt_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Counter is held clear here, so a tick alongside game_over is not counted.
          fcnt_clear = 1'b1;
          if (game_over) begin
            state_d   = StReveal;
            char_en_d = NUM_CHARS'(1);
            bcnt_d    = '0;
            winner_d  = winner;
          end
        end
        StReveal: begin
          if (phase_done) begin
            if (&char_en_q) begin
              state_d   = StBlink;
              char_en_d = '0;
            end else begin
              char_en_d = {char_en_q[NUM_CHARS-2:0], 1'b1};
            end
          end
        end
        StBlink: begin
          if (phase_done) begin
            if (char_en_q == '0) begin
              // Off->on: one more completed blink.
              char_en_d = '1;
              bcnt_d    = bcnt_q + BcntW'(1);
            end else if (bcnt_q == BcntW'(BLINK_COUNT)) begin
              // Last on-phase has run its full length; keep the banner lit.
              state_d = StHold;
            end else begin
              char_en_d = '0;
            end
          end
        end
        StHold: begin
          fcnt_clear = 1'b1;
          char_en_d  = '1;
        end
        default: begin
          state_d   = StIdle;
          char_en_d = '0;
        end
      endcase
    end
    active_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      char_en_q <= '0;
      bcnt_q    <= '0;
      winner_qq <= 1'b0;
      active_q  <= 1'b0;
      base_x_q  <= 10'(BASE_X);
      base_y_q  <= 10'(BASE_Y);
    end else begin
      state_q   <= state_d;
      char_en_q <= char_en_d;
      bcnt_q    <= bcnt_d;
      winner_qq <= winner_d;
      active_q  <= active_d;
      base_x_q  <= 10'(BASE_X);
      base_y_q  <= 10'(BASE_Y);
    end
  end

  assign char_en  = char_en_q;
  assign winner_q = winner_qq;
  assign active   = active_q;
  assign base_x   = base_x_q;
  assign base_y   = base_y_q;

endmodule
